// File: rtl/pipe_adder_pkg.sv
// Shared constants, digit type and BCD helpers for the pipelined carry-skip adder.
package pipe_adder_pkg;

  localparam int unsigned DIG_W = 4;

  typedef logic [DIG_W-1:0] digit_t;

  // Nines-complement of one BCD digit (decimal counterpart of bit inversion).
  function automatic digit_t nines_comp(input digit_t d);
    return digit_t'(4'd9 - d);
  endfunction

  // Decimal adjust of a raw 5-bit digit sum: returns {carry, digit}.
  function automatic logic [DIG_W:0] dec_correct(input logic [DIG_W:0] raw5);
    logic [DIG_W:0] t;
    t = raw5;
    if (raw5 > 5'd9) begin
      t         = raw5 + 5'd6;
      t[DIG_W]  = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/skip_group.sv
// One 4-bit carry-skip digit group; binary, or BCD when PIPE_SKIP_ADDER_DEC_EN
// is defined and dec=1.
module skip_group
  import pipe_adder_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  input  logic   cin,
`ifdef PIPE_SKIP_ADDER_DEC_EN
  input  logic   dec,
`endif
  output digit_t sum,
  output logic   cout,
  output logic   prop
);

  logic [DIG_W:0] w_raw;
  logic           w_rip_c;
  digit_t         w_dig;

  assign w_raw = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, cin};

`ifdef PIPE_SKIP_ADDER_DEC_EN
  logic [DIG_W:0] w_pair;
  logic [DIG_W:0] w_corr;

  assign w_pair = {1'b0, a} + {1'b0, b};
  assign w_corr = dec_correct(w_raw);

  // Select binary or decimal digit result and propagate condition.
  always_comb begin
    prop    = &(a ^ b);
    w_rip_c = w_raw[DIG_W];
    w_dig   = w_raw[DIG_W-1:0];
    if (dec) begin
      prop    = (w_pair == 5'd9);
      w_rip_c = w_corr[DIG_W];
      w_dig   = w_corr[DIG_W-1:0];
    end
  end
`else
  assign prop    = &(a ^ b);
  assign w_rip_c = w_raw[DIG_W];
  assign w_dig   = w_raw[DIG_W-1:0];
`endif

  // When every bit propagates the incoming carry bypasses the ripple path.
  assign cout = prop ? cin : w_rip_c;
  assign sum  = w_dig;

endmodule

// File: rtl/pipe_skip_adder.sv
// Pipelined carry-skip adder/subtractor, STG digit groups per stage,
// LAT = NDIG/STG register stages, valid/ready on both sides.
// Optional BCD mode: define PIPE_SKIP_ADDER_DEC_EN (adds input dec).
module pipe_skip_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned NDIG = 4,
  parameter int unsigned STG  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIG_W*NDIG-1:0]   a,
  input  logic [DIG_W*NDIG-1:0]   b,
  input  logic                    cin,
  input  logic                    op_sub,
`ifdef PIPE_SKIP_ADDER_DEC_EN
  input  logic                    dec,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIG_W*NDIG-1:0]   sum,
  output logic                    cout
);

  localparam int unsigned W   = DIG_W * NDIG;
  localparam int unsigned LAT = NDIG / STG;

  // Stage registers: operands ride along so later stages see their digits,
  // finished lower sum digits ride along so the output word is aligned.
  logic         r_vld [LAT];
  logic [W-1:0] r_a   [LAT];
  logic [W-1:0] r_b   [LAT];
  logic [W-1:0] r_s   [LAT];
  logic         r_c   [LAT];

  // Stage inputs and combinational stage results.
  logic         w_vld_in [LAT];
  logic [W-1:0] w_a_in   [LAT];
  logic [W-1:0] w_b_in   [LAT];
  logic [W-1:0] w_s_in   [LAT];
  logic         w_c_in   [LAT];
  logic [W-1:0] w_s_nxt  [LAT];
  logic         w_c_nxt  [LAT];

  logic         w_adv;
  logic [W-1:0] w_b_cap;

`ifdef PIPE_SKIP_ADDER_DEC_EN
  logic         r_dec    [LAT];
  logic         w_dec_in [LAT];
`endif

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[LAT-1];
  assign sum       = r_s[LAT-1];
  assign cout      = r_c[LAT-1];

  // Condition operand B at capture: bit inversion (binary) or per-digit
  // nines-complement (decimal) for subtraction.
  always_comb begin
    w_b_cap = b;
    if (op_sub) begin
`ifdef PIPE_SKIP_ADDER_DEC_EN
      if (dec) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          w_b_cap[i*DIG_W +: DIG_W] = nines_comp(b[i*DIG_W +: DIG_W]);
        end
      end else begin
        w_b_cap = ~b;
      end
`else
      w_b_cap = ~b;
`endif
    end
  end

  genvar k, j;
  for (k = 0; k < LAT; k++) begin : g_stg
    logic [STG:0]   w_cc;
    logic [STG-1:0] w_prop;

    if (k == 0) begin : g_first
      assign w_vld_in[k] = in_valid;
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = w_b_cap;
      assign w_s_in[k]   = '0;
      assign w_c_in[k]   = cin;
`ifdef PIPE_SKIP_ADDER_DEC_EN
      assign w_dec_in[k] = dec;
`endif
    end else begin : g_next
      assign w_vld_in[k] = r_vld[k-1];
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_s_in[k]   = r_s[k-1];
      assign w_c_in[k]   = r_c[k-1];
`ifdef PIPE_SKIP_ADDER_DEC_EN
      assign w_dec_in[k] = r_dec[k-1];
`endif
    end

    assign w_cc[0] = w_c_in[k];

    for (j = 0; j < NDIG; j++) begin : g_dig
      if (j / STG == k) begin : g_act
        skip_group u_grp (
          .a    (w_a_in[k][j*DIG_W +: DIG_W]),
          .b    (w_b_in[k][j*DIG_W +: DIG_W]),
          .cin  (w_cc[j%STG]),
`ifdef PIPE_SKIP_ADDER_DEC_EN
          .dec  (w_dec_in[k]),
`endif
          .sum  (w_s_nxt[k][j*DIG_W +: DIG_W]),
          .cout (w_cc[j%STG+1]),
          .prop (w_prop[j%STG])
        );
      end else begin : g_pass
        assign w_s_nxt[k][j*DIG_W +: DIG_W] = w_s_in[k][j*DIG_W +: DIG_W];
      end
    end

    // Stage-level skip: a fully propagating stage forwards its carry-in.
    assign w_c_nxt[k] = (&w_prop) ? w_c_in[k] : w_cc[STG];
  end

  // Shift the whole pipe on advance; data registers load only with valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_s[i]   <= '0;
        r_c[i]   <= 1'b0;
`ifdef PIPE_SKIP_ADDER_DEC_EN
        r_dec[i] <= 1'b0;
`endif
      end
    end else if (w_adv) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_vld[i] <= w_vld_in[i];
        if (w_vld_in[i]) begin
          r_a[i]   <= w_a_in[i];
          r_b[i]   <= w_b_in[i];
          r_s[i]   <= w_s_nxt[i];
          r_c[i]   <= w_c_nxt[i];
`ifdef PIPE_SKIP_ADDER_DEC_EN
          r_dec[i] <= w_dec_in[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_skip_adder.sv
// Directed bench for pipe_skip_adder (NDIG=4, STG=2, latency 2).
module tb_pipe_skip_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        dec;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        op_sub;
`ifdef PIPE_SKIP_ADDER_DEC_EN
  logic        dec;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int unsigned n_tests;
  int unsigned n_fail;

  pipe_skip_adder #(.NDIG(4), .STG(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
`ifdef PIPE_SKIP_ADDER_DEC_EN
    .dec       (dec),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                              input logic vs, input logic vd, input logic [15:0] es,
                              input logic ec);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.dec = vd;
    v.exp_sum = es; v.exp_cout = ec;
    return v;
  endfunction

  // Send one beat into an empty pipe and check result and latency.
  task automatic run_vec(input vec_t v, input string tag);
    int unsigned cyc;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; op_sub = v.sub;
`ifdef PIPE_SKIP_ADDER_DEC_EN
    dec = v.dec;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"},  cyc, 32'd2);
    chk({tag, "_sum"},  {16'h0, sum}, {16'h0, v.exp_sum});
    chk({tag, "_cout"}, {31'h0, cout}, {31'h0, v.exp_cout});
  endtask

  vec_t vecs[$];

  initial begin
    int unsigned seen;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    out_ready = 1'b1;
`ifdef PIPE_SKIP_ADDER_DEC_EN
    dec = 1'b0;
`endif

    //                a         b         cin   sub   dec   sum       cout
    vecs.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h1234, 16'h0235, 1'b1, 1'b1, 1'b0, 16'h0FFF, 1'b1));
    vecs.push_back(mk(16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0));
    vecs.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0));
    vecs.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0));
    vecs.push_back(mk(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0));
    vecs.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1));
    vecs.push_back(mk(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 16'h3334, 1'b0));
`ifdef PIPE_SKIP_ADDER_DEC_EN
    vecs.push_back(mk(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b0));
    vecs.push_back(mk(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1));
    vecs.push_back(mk(16'h0100, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0099, 1'b1));
`endif

    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum",       {16'h0, sum},       32'h0);
    chk("rst_cout",      {31'h0, cout},      32'h0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back beats with a two-cycle output stall.
`ifdef PIPE_SKIP_ADDER_DEC_EN
    dec = 1'b0;
`endif
    @(negedge clk);
    out_ready = 1'b1; op_sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    a = 16'h0002; b = 16'h0002;
    @(negedge clk);
    chk("stall_first_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_first_sum",   {16'h0, sum},       32'h2);
    out_ready = 1'b0; a = 16'h0003; b = 16'h0003;
    #1;
    chk("stall_in_ready0", {31'h0, in_ready}, 32'h0);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d_valid", s), {31'h0, out_valid}, 32'h1);
      chk($sformatf("stall_hold%0d_sum", s),   {16'h0, sum},       32'h2);
      chk($sformatf("stall_hold%0d_ready", s), {31'h0, in_ready},  32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_second_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_second_sum",   {16'h0, sum},       32'h4);
    @(negedge clk);
    chk("stall_third_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_third_sum",   {16'h0, sum},       32'h6);
    @(negedge clk);
    chk("stall_drained", {31'h0, out_valid}, 32'h0);

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0007; b = 16'h0007;
    @(negedge clk);
    a = 16'h0008; b = 16'h0008;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_sum",   {16'h0, sum},       32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("postrst_no_output", seen, 32'd0);
    run_vec(mk(16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b0), "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
